// File: rtl/core_mem_pkg.sv
// Shared definitions for the core-memory write sequencer: state encoding,
// word geometry, odd-parity and module-select helpers.
package core_mem_pkg;

    localparam int SYL_BITS  = 13;
    localparam int WORD_BITS = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_STROBE,
        ST_SAMPLE,
        ST_INHSET,
        ST_WRITE,
        ST_RECOVER
    } seq_state_t;

    // Bit 14 value that makes the 14-bit word contain an odd number of ones.
    // Checking a stored word is odd_parity(word[13:1]) == word[14].
    function automatic logic odd_parity(input logic [SYL_BITS-1:0] bits);
        return ~(^bits);
    endfunction

    function automatic logic [7:0] module_onehot(input logic [2:0] mod);
        return 8'b1 << mod;
    endfunction

endpackage

// File: rtl/core_phase_timer.sv
// Loadable down-counter for the multi-clock READ and WRITE phases;
// tc is high while the count sits at 1 (last clock of the phase).
module core_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count > WIDTH'(1)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == WIDTH'(1));

endmodule

// File: rtl/core_write_sequencer.sv
// One core-memory read/restore cycle per START: read drive, sense strobe,
// data sample, inhibit setup, write drive, recovery. Optional parity check
// on regenerated words is built only when PARITY_CHECK_EN is defined.
module core_write_sequencer
    import core_mem_pkg::*;
#(
    parameter int READ_CYCLES  = 4,
    parameter int WRITE_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 WRITE,
    input  logic [2:0]           MOD,
    input  logic [SYL_BITS-1:0]  WDATA,
    input  logic [WORD_BITS-1:0] BR_A,
    input  logic [WORD_BITS-1:0] BR_B,
    output logic [7:0]           MSEL,
    output logic                 RDRV,
    output logic                 STRB,
    output logic                 WDRV,
    output logic [WORD_BITS-1:0] INH,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PERR
);

    localparam logic [3:0] READ_LOAD  = 4'(READ_CYCLES);
    localparam logic [3:0] WRITE_LOAD = 4'(WRITE_CYCLES);

    seq_state_t           state, next_state;
    logic                 timer_load;
    logic [3:0]           timer_value;
    logic                 timer_tc;
    logic                 req_write;
    logic [2:0]           req_mod;
    logic [SYL_BITS-1:0]  req_wdata;
    logic [WORD_BITS-1:0] data_reg;
    logic [WORD_BITS-1:0] sel_word;
    logic                 accept;

    assign accept   = (state == ST_IDLE) && START;
    assign sel_word = req_mod[0] ? BR_B : BR_A;

    core_phase_timer #(.WIDTH(4)) u_phase_timer (
        .clk        (CLK),
        .rst        (RESET),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (timer_tc)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Every transition reloads the timer; single-clock states load 1.
    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = 4'd1;
        MSEL        = '0;
        RDRV        = 1'b0;
        STRB        = 1'b0;
        WDRV        = 1'b0;
        INH         = '0;
        DONE        = 1'b0;
        BUSY        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (START) begin
                    next_state  = ST_READ;
                    timer_load  = 1'b1;
                    timer_value = READ_LOAD;
                end
            end
            ST_READ: begin
                MSEL = module_onehot(req_mod);
                RDRV = 1'b1;
                if (timer_tc) begin
                    next_state = ST_STROBE;
                    timer_load = 1'b1;
                end
            end
            ST_STROBE: begin
                MSEL       = module_onehot(req_mod);
                STRB       = 1'b1;
                next_state = ST_SAMPLE;
                timer_load = 1'b1;
            end
            ST_SAMPLE: begin
                MSEL       = module_onehot(req_mod);
                next_state = ST_INHSET;
                timer_load = 1'b1;
            end
            ST_INHSET: begin
                MSEL        = module_onehot(req_mod);
                INH         = ~data_reg;
                next_state  = ST_WRITE;
                timer_load  = 1'b1;
                timer_value = WRITE_LOAD;
            end
            ST_WRITE: begin
                MSEL = module_onehot(req_mod);
                INH  = ~data_reg;
                WDRV = 1'b1;
                if (timer_tc) begin
                    next_state = ST_RECOVER;
                    timer_load = 1'b1;
                end
            end
            ST_RECOVER: begin
                DONE       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            req_write <= 1'b0;
            req_mod   <= '0;
            req_wdata <= '0;
            data_reg  <= '0;
        end else begin
            if (accept) begin
                req_write <= WRITE;
                req_mod   <= MOD;
                req_wdata <= WDATA;
            end
            if (state == ST_SAMPLE) begin
                if (req_write) begin
                    data_reg <= {odd_parity(req_wdata), req_wdata};
                end else begin
                    data_reg <= sel_word;
                end
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic perr_reg;

    // Sticky until the next accepted request; the word is restored as read.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            perr_reg <= 1'b0;
        end else if (accept) begin
            perr_reg <= 1'b0;
        end else if ((state == ST_SAMPLE) && !req_write &&
                     (odd_parity(sel_word[SYL_BITS-1:0]) != sel_word[WORD_BITS-1])) begin
            perr_reg <= 1'b1;
        end
    end

    assign PERR = perr_reg;
`else
    assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_core_write_sequencer.sv
// Self-checking bench for core_write_sequencer: vector table, directed
// corner sequences and randomized cycles against a timeline model.
module tb_core_write_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic        WRITE;
    logic [2:0]  MOD;
    logic [12:0] WDATA;
    logic [13:0] BR_A;
    logic [13:0] BR_B;

    logic [7:0]  msel0, msel1;
    logic        rdrv0, rdrv1, strb0, strb1, wdrv0, wdrv1;
    logic [13:0] inh0, inh1;
    logic        busy0, busy1, done0, done1, perr0, perr1;

    always #5 CLK = ~CLK;

    core_write_sequencer #(.READ_CYCLES(4), .WRITE_CYCLES(4)) dut0 (
        .CLK(CLK), .RESET(RESET), .START(START), .WRITE(WRITE), .MOD(MOD),
        .WDATA(WDATA), .BR_A(BR_A), .BR_B(BR_B), .MSEL(msel0), .RDRV(rdrv0),
        .STRB(strb0), .WDRV(wdrv0), .INH(inh0), .BUSY(busy0), .DONE(done0),
        .PERR(perr0)
    );

    core_write_sequencer #(.READ_CYCLES(2), .WRITE_CYCLES(15)) dut1 (
        .CLK(CLK), .RESET(RESET), .START(START), .WRITE(WRITE), .MOD(MOD),
        .WDATA(WDATA), .BR_A(BR_A), .BR_B(BR_B), .MSEL(msel1), .RDRV(rdrv1),
        .STRB(strb1), .WDRV(wdrv1), .INH(inh1), .BUSY(busy1), .DONE(done1),
        .PERR(perr1)
    );

    typedef logic [27:0] obs_t;  // {msel, rdrv, strb, wdrv, inh, busy, done, perr}

    typedef struct {
        logic        wr;
        logic [2:0]  mod;
        logic [12:0] wdata;
        logic [13:0] bra;
        logic [13:0] brb;
        logic [7:0]  msel;
        logic [13:0] inh;
    } vec_t;

    int tests = 0;
    int fails = 0;

    function automatic obs_t observe(input int sel);
        if (sel == 0) return {msel0, rdrv0, strb0, wdrv0, inh0, busy0, done0, perr0};
        return {msel1, rdrv1, strb1, wdrv1, inh1, busy1, done1, perr1};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Word the core should hold after the restore half-cycle.
    function automatic logic [13:0] exp_word(input logic wr, input logic [2:0] m,
                                             input logic [12:0] wd,
                                             input logic [13:0] a, input logic [13:0] b);
        if (wr) return {($countones(wd) % 2) == 0, wd};
        return m[0] ? b : a;
    endfunction

    function automatic logic exp_bad(input logic wr, input logic [2:0] m,
                                     input logic [13:0] a, input logic [13:0] b);
        if (wr) return 1'b0;
        return ($countones(m[0] ? b : a) % 2) == 0;
    endfunction

    // Expected outputs k clocks after the accepting START edge.
    function automatic obs_t model(input int k, input int rc, input int wc,
                                   input logic [13:0] word, input logic [2:0] m,
                                   input logic bad);
        int          n;
        logic [7:0]  ms;
        logic [13:0] ih;
        logic        rd, st, wd, bz, dn, pe;
        n  = rc + wc + 4;
        rd = (k >= 1) && (k <= rc);
        st = (k == rc + 1);
        wd = (k >= rc + 4) && (k <= rc + wc + 3);
        ih = ((k >= rc + 3) && (k <= rc + wc + 3)) ? ~word : 14'h0;
        ms = ((k >= 1) && (k <= rc + wc + 3)) ? (8'b1 << m) : 8'h0;
        bz = (k >= 1) && (k <= n);
        dn = (k == n);
`ifdef PARITY_CHECK_EN
        pe = bad && (k >= rc + 3);
`else
        pe = 1'b0 & bad;
`endif
        return {ms, rd, st, wd, ih, bz, dn, pe};
    endfunction

    task automatic run_txn(input int sel, input int rc, input int wc, input logic wr,
                           input logic [2:0] m, input logic [12:0] wd,
                           input logic [13:0] a, input logic [13:0] b,
                           input bit noise, input string tag,
                           output logic [7:0] msel_cap, output logic [13:0] inh_cap);
        int          n;
        obs_t        obs;
        logic [13:0] word;
        logic        bad;
        n        = rc + wc + 4;
        word     = exp_word(wr, m, wd, a, b);
        bad      = exp_bad(wr, m, a, b);
        msel_cap = '0;
        inh_cap  = '0;
        WRITE = wr; MOD = m; WDATA = wd;
        BR_A = 14'($urandom); BR_B = 14'($urandom);
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        WRITE = 1'($urandom); MOD = 3'($urandom); WDATA = 13'($urandom);
        for (int k = 1; k <= n + 1; k++) begin
            obs = observe(sel);
            check($sformatf("%s c%0d", tag, k), obs, model(k, rc, wc, word, m, bad));
            if (k == rc + 4) begin
                msel_cap = obs[27:20];
                inh_cap  = obs[16:3];
            end
            if (k == rc + 2) begin
                BR_A = a; BR_B = b;
            end else begin
                BR_A = 14'($urandom); BR_B = 14'($urandom);
            end
            START = (noise && (k <= n)) ? 1'($urandom) : 1'b0;
            if (k <= n) begin
                @(posedge CLK); #1;
            end
        end
    endtask

    vec_t        vecs[7];
    logic [7:0]  cap_msel;
    logic [13:0] cap_inh;

    initial begin
        RESET = 1'b1; START = 1'b0; WRITE = 1'b0; MOD = '0; WDATA = '0;
        BR_A = '0; BR_B = '0;
        vecs[0] = '{1'b1, 3'd2, 13'h0001, 14'h0000, 14'h0000, 8'h04, 14'h3FFE};
        vecs[1] = '{1'b0, 3'd5, 13'h0000, 14'h3FFF, 14'h2000, 8'h20, 14'h1FFF};
        vecs[2] = '{1'b1, 3'd7, 13'h0000, 14'h0000, 14'h0000, 8'h80, 14'h1FFF};
        vecs[3] = '{1'b1, 3'd0, 13'h1FFF, 14'h0000, 14'h0000, 8'h01, 14'h2000};
        vecs[4] = '{1'b0, 3'd0, 13'h0000, 14'h2AAA, 14'h0000, 8'h01, 14'h1555};
        vecs[5] = '{1'b0, 3'd3, 13'h0000, 14'h3FFF, 14'h0001, 8'h08, 14'h3FFE};
        vecs[6] = '{1'b0, 3'd0, 13'h0000, 14'h0000, 14'h1234, 8'h01, 14'h3FFF};

        repeat (2) @(posedge CLK);
        #1;
        check("reset dut0", observe(0), '0);
        check("reset dut1", observe(1), '0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Table vectors back-to-back; the second one also gets stray STARTs.
        for (int i = 0; i < 7; i++) begin
            run_txn(0, 4, 4, vecs[i].wr, vecs[i].mod, vecs[i].wdata, vecs[i].bra,
                    vecs[i].brb, (i == 1), $sformatf("vec%0d", i), cap_msel, cap_inh);
            check($sformatf("vec%0d msel", i), obs_t'(cap_msel), obs_t'(vecs[i].msel));
            check($sformatf("vec%0d inh", i), obs_t'(cap_inh), obs_t'(vecs[i].inh));
        end

        // START on the DONE cycle is dropped: stays idle afterwards.
        WRITE = 1'b1; MOD = 3'd1; WDATA = 13'h0F0F; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) begin
            @(posedge CLK); #1;
        end
        check("pre-done", obs_t'(done0), obs_t'(1'b0));
        @(posedge CLK); #1;
        check("done c12", obs_t'({busy0, done0}), obs_t'(2'b11));
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("start on done ignored", observe(0), '0);
        @(posedge CLK); #1;
        check("still idle", observe(0), '0);

        // Asynchronous reset in the middle of WRITE.
        WRITE = 1'b1; MOD = 3'd6; WDATA = 13'h0AAA; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (8) begin
            @(posedge CLK); #1;
        end
        check("pre-reset wdrv", obs_t'(wdrv0), obs_t'(1'b1));
        #2 RESET = 1'b1;
        #1 check("async reset drop", observe(0), '0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("post-reset idle %0d", k), observe(0), '0);
            @(posedge CLK); #1;
        end
        run_txn(0, 4, 4, 1'b1, 3'd4, 13'h1555, 14'h0, 14'h0, 1'b0, "after-reset",
                cap_msel, cap_inh);

        // Short read, long write build.
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        run_txn(1, 2, 15, 1'b0, 3'd1, 13'h0, 14'h0, 14'h2000, 1'b1, "r2w15",
                cap_msel, cap_inh);
        run_txn(1, 2, 15, 1'b1, 3'd6, 13'h0101, 14'h0, 14'h0, 1'b0, "r2w15b",
                cap_msel, cap_inh);

        // Randomized cycles with random idle gaps and stray STARTs.
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge CLK); #1;
            end
            run_txn(0, 4, 4, 1'($urandom), 3'($urandom), 13'($urandom),
                    14'($urandom), 14'($urandom), 1'b1, $sformatf("rnd%0d", i),
                    cap_msel, cap_inh);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
